frq_divider_multi: RTL
======================

Name: frq_divider_multi

Overview:
- Multi-channel, programmable-table clock divider; parametrised successor to the single-channel, 5-bit-select ROM-controlled divider.
- Each channel divides the system clock by a half-period value taken from a shared writable divisor table, indexed by a per-channel select.
- Adds per-channel enable, square/pulse output modes, a glitch-free select change (applied only at period boundaries) and a run-time table write port.
- Sits behind the TinyTapeout top wrapper; outputs drive uio/uo pins.

Parameters:
- N_CH, 2, number of independent divider channels.
- SEL_W, 5, select width; the table has 2**SEL_W entries.
- CNT_W, 16, width of table entries and per-channel down-counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- en  input  N_CH  per-channel enable.
- mode  input  N_CH  per-channel mode: 0 = square (50% duty), 1 = single-cycle pulse.
- sel  input  N_CH*SEL_W  per-channel table index; channel i uses bits [i*SEL_W +: SEL_W].
- wr_en  input  1  table write strobe.
- wr_addr  input  SEL_W  table write address.
- wr_data  input  CNT_W  table write data (half-period H).
- clk_out  output  N_CH  divided outputs, registered.
- tick  output  N_CH  one-cycle pulse per channel at each reload, registered.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset state:
  - table[k] = k+1 for every k;
  - every channel: cnt = 0, clk_out = 0, tick = 0, mode_q = 0.
  - Reset asserted mid-operation returns to this state on the next edge. Any previously written table content is lost.
- Table:
  - Single write port. Writes are visible from the cycle after the wr_en edge.
  - A reload in the same cycle as a write to the same entry uses the old value.
  - Reads are combinational, one read mux per channel.
  - Effective half-period H = max(table[sel], 1), so a stored 0 behaves as 1.
- Per channel, when en = 0: cnt <= 0, clk_out <= 0, tick <= 0. mode_q holds.
- Per channel, when en = 1 and cnt == 0 (reload):
  - cnt <= H(sel) - 1, with sel sampled this cycle;
  - mode_q <= mode;
  - tick <= 1;
  - clk_out <= ~clk_out if mode = 0, clk_out <= 1 if mode = 1.
- Per channel, when en = 1 and cnt != 0:
  - cnt <= cnt - 1; tick <= 0;
  - clk_out holds if mode_q = 0, clk_out <= 0 if mode_q = 1.
- Resulting periods:
  - Square mode: period 2H cycles, high for H cycles.
  - Pulse mode: period H cycles with a one-cycle high. H = 1 gives a constant 1.
- Latency: en rising (sampled at edge t) gives clk_out and tick high after edge t; the first reload happens immediately.
- sel and mode changes between reloads are ignored until the next reload. This keeps pulse widths glitch-free.
- Channels are fully independent apart from sharing the table.
- cnt is never decremented below 0; there is no wrap-around.

Test Plan:
- Reset defaults: reset 2 cycles -> clk_out = 0, tick = 0 on all channels. Readback via sel = 7 square gives H = 8, period 16.
- Square divide: ch0 en = 1, mode = 0, sel = 3 -> clk_out toggles every 4 cycles (period 8), tick every 4 cycles, first high after edge 1.
- Pulse and edge cases: ch1 mode = 1, sel = 0 -> clk_out constant 1. Switch sel = 4 -> one-cycle pulse every 5 cycles, starting only after the current period ends.
- Glitch-free select: ch0 square, sel = 9 (H = 10); change to sel = 1 at cycle 3 of the half-period -> current half-period still lasts 10 cycles, then 2-cycle half-periods.
- Table write: write addr 2 = 100 on the cycle ch0 (sel = 2) reloads -> that period uses 3; the next reload uses 100. Writing 0 -> behaves as H = 1.
- Enable/reset mid-run: drop en mid-period -> clk_out = 0 next cycle; re-enable -> restart from reload. Assert reset mid-run -> all outputs 0 and table entry 2 restored to 3.

Source files
------------

// File: rtl/frq_divider_multi.sv
// Multi-channel programmable clock divider: each channel divides clk by a half-period
// looked up in a shared, run-time writable divisor table.
module frq_divider_multi #(
  parameter int N_CH  = 2,
  parameter int SEL_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         en,
  input  logic [N_CH-1:0]         mode,
  input  logic [N_CH*SEL_W-1:0]   sel,
  input  logic                    wr_en,
  input  logic [SEL_W-1:0]        wr_addr,
  input  logic [CNT_W-1:0]        wr_data,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH-1:0]         tick
);

  localparam int DEPTH = 1 << SEL_W;

  logic [CNT_W-1:0] div_tab    [DEPTH];
  logic [CNT_W-1:0] cnt        [N_CH];
  logic [CNT_W-1:0] rd_val     [N_CH];
  logic [CNT_W-1:0] reload_val [N_CH];
  logic [N_CH-1:0]  mode_q;

  // A stored 0 behaves as half-period 1, so the reload count is max(H,1)-1.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      rd_val[i]     = div_tab[sel[i*SEL_W +: SEL_W]];
      reload_val[i] = '0;
      if (rd_val[i] != '0) reload_val[i] = rd_val[i] - CNT_W'(1);
    end
  end

  // NOTE: the table is built from flops, not a RAM macro, so it can take its k+1
  // defaults on reset; a real SRAM could not be reset this way.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) div_tab[k] <= CNT_W'(k + 1);
    end else if (wr_en) begin
      div_tab[wr_addr] <= wr_data;
    end
  end

  // Reloads read the pre-write table contents because the write lands on the same edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        cnt[i]     <= '0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
        mode_q[i]  <= 1'b0;
      end else if (!en[i]) begin
        cnt[i]     <= '0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
      end else if (cnt[i] == '0) begin
        cnt[i]     <= reload_val[i];
        mode_q[i]  <= mode[i];
        tick[i]    <= 1'b1;
        clk_out[i] <= mode[i] ? 1'b1 : ~clk_out[i];
      end else begin
        cnt[i]     <= cnt[i] - CNT_W'(1);
        tick[i]    <= 1'b0;
        if (mode_q[i]) clk_out[i] <= 1'b0;
      end
    end
  end

endmodule
